// File: rtl/block_pack_buffer.sv
// block_pack_buffer
//   Streaming packer. Each input beat carries 0..ELMS valid elements in lanes
//   0..in_cnt-1 (lane 0 oldest). Elements are appended behind the residue and
//   emitted as dense ELMS-element blocks. A flush request drains any residue as
//   a partial block.
//
// Ports
//   clk, reset            clock, synchronous active-high reset
//   in_valid/in_ready     input beat handshake
//   in_cnt, in_data       valid element count and element lanes of the beat
//   flush                 request to emit the residue as a partial block
//   out_valid/out_ready   output block handshake
//   out_cnt, out_data     element count and lanes of the output block
//   fill                  number of residue elements held (0..ELMS-1)
//   flush_done            one-cycle pulse when a flush has completed
//
// State table
//   RUN   | accepting beats; flush request moves to DRAIN
//   DRAIN | input blocked; waits for a free output slot, emits residue (if any)

// block_shift
//   Moves whole elements of a block by amt positions (0..ELMS). LEFT=1 moves
//   element i to i+amt, LEFT=0 moves element i to i-amt. Vacated lanes are zero.
//
// Ports
//   data_in   block to shift
//   amt       shift distance in elements
//   data_out  shifted block
module block_shift #(
  parameter int ELMS = 8,
  parameter int DATA = 8,
  parameter int CNT  = $clog2(ELMS + 1),
  parameter bit LEFT = 1'b1
) (
  input  logic [ELMS-1:0][DATA-1:0] data_in,
  input  logic [CNT-1:0]            amt,
  output logic [ELMS-1:0][DATA-1:0] data_out
);

  localparam int W  = ELMS * DATA;
  localparam int SW = $clog2(W + 1);

  logic [W-1:0]  flat;
  logic [SW-1:0] sh_bits;

  assign flat    = data_in;
  assign sh_bits = SW'(amt) * SW'(DATA);

  generate
    if (LEFT) begin : g_left
      assign data_out = flat << sh_bits;
    end else begin : g_right
      assign data_out = flat >> sh_bits;
    end
  endgenerate

endmodule

module block_pack_buffer #(
  parameter  int ELMS = 8,
  parameter  int DATA = 8,
  localparam int CNT  = $clog2(ELMS + 1)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [CNT-1:0]            in_cnt,
  input  logic [ELMS-1:0][DATA-1:0] in_data,
  input  logic                      flush,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [CNT-1:0]            out_cnt,
  output logic [ELMS-1:0][DATA-1:0] out_data,
  output logic [CNT-1:0]            fill,
  output logic                      flush_done
);

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_DRAIN = 1'b1
  } state_t;

  state_t state, state_nxt;

  logic [ELMS-1:0][DATA-1:0] residue;
  logic [ELMS-1:0][DATA-1:0] masked;
  logic [ELMS-1:0][DATA-1:0] shl_data;
  logic [ELMS-1:0][DATA-1:0] shr_data;
  logic [ELMS-1:0][DATA-1:0] comb_data;
  logic [CNT-1:0]            shr_amt;
  logic [CNT:0]              total;
  logic                      slot_free;
  logic                      accept;
  logic                      emit_full;
  logic                      drain_go;

  // Lanes at or above in_cnt are zeroed so stale data never reaches the
  // residue or the output block.
  always_comb begin
    masked = '0;
    for (int i = 0; i < ELMS; i++) begin
      if (CNT'(i) < in_cnt) masked[i] = in_data[i];
    end
  end

  // New elements land directly behind the residue.
  block_shift #(.ELMS(ELMS), .DATA(DATA), .CNT(CNT), .LEFT(1'b1)) u_shl (
    .data_in  (masked),
    .amt      (fill),
    .data_out (shl_data)
  );

  // Elements that spill past the block boundary become the next residue.
  assign shr_amt = CNT'(ELMS) - fill;

  block_shift #(.ELMS(ELMS), .DATA(DATA), .CNT(CNT), .LEFT(1'b0)) u_shr (
    .data_in  (masked),
    .amt      (shr_amt),
    .data_out (shr_data)
  );

  assign comb_data = residue | shl_data;
  assign total     = {1'b0, fill} + {1'b0, in_cnt};
  assign slot_free = !out_valid || out_ready;
  assign accept    = in_valid && in_ready;
  assign emit_full = accept && (total >= (CNT+1)'(ELMS));

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= ST_RUN;
    else       state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      ST_RUN:   if (flush)     state_nxt = ST_DRAIN;
      ST_DRAIN: if (slot_free) state_nxt = ST_RUN;
      default:                 state_nxt = ST_RUN;
    endcase
  end

  // Output / control decode
  always_comb begin
    in_ready = 1'b0;
    drain_go = 1'b0;
    case (state)
      ST_RUN:   in_ready = slot_free;
      ST_DRAIN: drain_go = slot_free;
      default: begin
        in_ready = 1'b0;
        drain_go = 1'b0;
      end
    endcase
  end

  // Datapath. accept and drain_go are exclusive because they decode
  // different states.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid  <= 1'b0;
      out_cnt    <= '0;
      out_data   <= '0;
      fill       <= '0;
      residue    <= '0;
      flush_done <= 1'b0;
    end else begin
      flush_done <= 1'b0;

      if (out_valid && out_ready) out_valid <= 1'b0;

      if (accept) begin
        if (emit_full) begin
          out_data  <= comb_data;
          out_cnt   <= CNT'(ELMS);
          out_valid <= 1'b1;
          residue   <= shr_data;
          fill      <= CNT'(total - (CNT+1)'(ELMS));
        end else begin
          residue <= comb_data;
          fill    <= total[CNT-1:0];
        end
      end

      if (drain_go) begin
        flush_done <= 1'b1;
        if (fill != '0) begin
          out_data  <= residue;
          out_cnt   <= fill;
          out_valid <= 1'b1;
          residue   <= '0;
          fill      <= '0;
        end
      end
    end
  end

  // A beat claiming more than ELMS elements has no defined meaning.
  a_in_cnt_legal : assert property (
    @(posedge clk) disable iff (reset)
    (in_valid && in_ready) |-> (in_cnt <= CNT'(ELMS))
  );

endmodule

// File: tb/tb_block_pack_buffer.sv
module tb_block_pack_buffer;

  localparam int ELMS = 8;
  localparam int DATA = 8;
  localparam int CNT  = 4;

  logic                      clk;
  logic                      reset;
  logic                      in_valid;
  logic                      in_ready;
  logic [CNT-1:0]            in_cnt;
  logic [ELMS-1:0][DATA-1:0] in_data;
  logic                      flush;
  logic                      out_valid;
  logic                      out_ready;
  logic [CNT-1:0]            out_cnt;
  logic [ELMS-1:0][DATA-1:0] out_data;
  logic [CNT-1:0]            fill;
  logic                      flush_done;

  block_pack_buffer #(.ELMS(ELMS), .DATA(DATA)) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_cnt     (in_cnt),
    .in_data    (in_data),
    .flush      (flush),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_cnt    (out_cnt),
    .out_data   (out_data),
    .fill       (fill),
    .flush_done (flush_done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic [3:0]  cnt;
    logic [63:0] data;
  } blk_t;

  logic [7:0] model_q[$];
  blk_t       exp_q[$];
  int         checks;
  int         failures;
  int         flushes_issued;
  int         flush_pulses;
  bit         draining;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] mk(input logic [7:0] base, input int n);
    logic [63:0] r;
    for (int i = 0; i < ELMS; i++) begin
      if (i < n) r[i*8 +: 8] = base + 8'(i);
      else       r[i*8 +: 8] = 8'($urandom);
    end
    return r;
  endfunction

  task automatic push_block(input int n);
    blk_t b;
    b.cnt  = 4'(n);
    b.data = '0;
    for (int i = 0; i < n; i++) b.data[i*8 +: 8] = model_q.pop_front();
    exp_q.push_back(b);
  endtask

  // One clock cycle: drive at the falling edge, sample 1ns later, model the
  // handshakes that the next rising edge will perform.
  task automatic cycle(input logic v, input logic [3:0] cnt, input logic [63:0] d,
                       input logic rdy, input logic fl);
    blk_t b;
    in_valid  = v;
    in_cnt    = cnt;
    in_data   = d;
    out_ready = rdy;
    flush     = fl;
    #1;
    if (flush_done) begin
      flush_pulses++;
      check("flush_done_expected", 64'(flush_done), 64'(draining));
      draining = 1'b0;
    end
    if (!draining) check("fill", 64'(fill), 64'(model_q.size()));
    check("in_ready", 64'(in_ready), 64'(!draining && (!out_valid || out_ready)));
    if (out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        check("spurious_block", 64'(out_valid), 64'(0));
      end else begin
        b = exp_q.pop_front();
        check("out_cnt", 64'(out_cnt), 64'(b.cnt));
        check("out_data", out_data, b.data);
      end
    end
    if (v && in_ready) begin
      for (int i = 0; i < int'(cnt); i++) model_q.push_back(d[i*8 +: 8]);
      while (model_q.size() >= ELMS) push_block(ELMS);
    end
    if (fl && !draining) begin
      if (model_q.size() > 0) push_block(model_q.size());
      draining = 1'b1;
      flushes_issued++;
    end
    @(negedge clk);
  endtask

  task automatic idle(input logic rdy);
    cycle(1'b0, 4'd0, 64'd0, rdy, 1'b0);
  endtask

  task automatic wait_drain();
    for (int k = 0; k < 40 && draining; k++) idle(1'b1);
    check("drain_done", 64'(draining), 64'(0));
  endtask

  logic [63:0] vec;
  logic [63:0] dvec;
  int          pulses_before;
  int          seq;

  initial begin
    checks = 0;
    failures = 0;
    flushes_issued = 0;
    flush_pulses = 0;
    draining = 1'b0;
    reset = 1'b1;
    in_valid = 1'b0;
    in_cnt = '0;
    in_data = '0;
    flush = 1'b0;
    out_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("rst_out_valid", 64'(out_valid), 64'(0));
    check("rst_out_cnt", 64'(out_cnt), 64'(0));
    check("rst_out_data", out_data, 64'(0));
    check("rst_fill", 64'(fill), 64'(0));
    check("rst_flush_done", 64'(flush_done), 64'(0));
    check("rst_in_ready", 64'(in_ready), 64'(1));
    reset = 1'b0;

    // Three 3-element beats form one block, one element left over
    cycle(1'b1, 4'd3, mk(8'hA0, 3), 1'b1, 1'b0);
    cycle(1'b1, 4'd3, mk(8'hB0, 3), 1'b1, 1'b0);
    cycle(1'b1, 4'd3, mk(8'hC0, 3), 1'b1, 1'b0);
    vec = {8'hC1, 8'hC0, 8'hB2, 8'hB1, 8'hB0, 8'hA2, 8'hA1, 8'hA0};
    check("t1_out_valid", 64'(out_valid), 64'(1));
    check("t1_out_data", out_data, vec);
    check("t1_out_cnt", 64'(out_cnt), 64'(8));
    check("t1_fill", 64'(fill), 64'(1));
    cycle(1'b0, 4'd0, 64'd0, 1'b1, 1'b1);
    wait_drain();

    // Full beat with empty residue, then a zero-count beat
    dvec = mk(8'hD0, 8);
    cycle(1'b1, 4'd8, dvec, 1'b1, 1'b0);
    check("t2_out_data", out_data, dvec);
    check("t2_out_cnt", 64'(out_cnt), 64'(8));
    check("t2_fill", 64'(fill), 64'(0));
    cycle(1'b1, 4'd0, mk(8'h55, 0), 1'b1, 1'b0);
    check("t2_cnt0_fill", 64'(fill), 64'(0));
    check("t2_cnt0_out_valid", 64'(out_valid), 64'(0));

    // Backpressure on a completed block
    dvec = mk(8'h10, 8);
    cycle(1'b1, 4'd8, dvec, 1'b0, 1'b0);
    for (int k = 0; k < 5; k++) begin
      cycle(1'b1, 4'd3, mk(8'h20, 3), 1'b0, 1'b0);
      check("t3_hold_data", out_data, dvec);
      check("t3_hold_cnt", 64'(out_cnt), 64'(8));
      check("t3_hold_in_ready", 64'(in_ready), 64'(0));
    end
    cycle(1'b1, 4'd3, mk(8'h20, 3), 1'b1, 1'b0);
    check("t3_after_fill", 64'(fill), 64'(3));
    cycle(1'b0, 4'd0, 64'd0, 1'b1, 1'b1);
    wait_drain();

    // Flush of a 5-element residue
    cycle(1'b1, 4'd5, mk(8'hE0, 5), 1'b1, 1'b0);
    check("t4_fill5", 64'(fill), 64'(5));
    pulses_before = flush_pulses;
    cycle(1'b0, 4'd0, 64'd0, 1'b1, 1'b1);
    check("t4_drain_in_ready", 64'(in_ready), 64'(0));
    wait_drain();
    check("t4_flush_pulse", 64'(flush_pulses - pulses_before), 64'(1));
    check("t4_fill0", 64'(fill), 64'(0));

    // Flush with nothing held
    pulses_before = flush_pulses;
    cycle(1'b0, 4'd0, 64'd0, 1'b1, 1'b1);
    wait_drain();
    check("t4b_flush_pulse", 64'(flush_pulses - pulses_before), 64'(1));
    check("t4b_out_valid", 64'(out_valid), 64'(0));

    // Flush coinciding with an accepted beat
    cycle(1'b1, 4'd3, mk(8'h30, 3), 1'b1, 1'b0);
    cycle(1'b1, 4'd2, mk(8'h40, 2), 1'b1, 1'b1);
    check("t5_out_valid_pending", 64'(out_valid), 64'(0));
    check("t5_fill", 64'(fill), 64'(5));
    wait_drain();

    // Reset with residue and a stalled block
    cycle(1'b1, 4'd6, mk(8'h50, 6), 1'b1, 1'b0);
    cycle(1'b1, 4'd8, mk(8'h60, 8), 1'b0, 1'b0);
    check("t6_pre_fill", 64'(fill), 64'(6));
    check("t6_pre_out_valid", 64'(out_valid), 64'(1));
    reset = 1'b1;
    idle(1'b0);
    reset = 1'b0;
    model_q.delete();
    exp_q.delete();
    draining = 1'b0;
    check("t6_out_valid", 64'(out_valid), 64'(0));
    check("t6_fill", 64'(fill), 64'(0));
    check("t6_in_ready", 64'(in_ready), 64'(1));
    dvec = mk(8'h70, 8);
    cycle(1'b1, 4'd8, dvec, 1'b1, 1'b0);
    check("t6_clean_block", out_data, dvec);

    // Random traffic
    seq = 8'h80;
    for (int n = 0; n < 600; n++) begin
      int  c;
      bit  v;
      bit  rdy;
      bit  fl;
      c   = $urandom_range(0, 8);
      v   = ($urandom_range(0, 3) != 0);
      rdy = ($urandom_range(0, 3) != 0);
      fl  = !draining && ($urandom_range(0, 19) == 0);
      cycle(v, 4'(c), mk(8'(seq), c), rdy, fl);
      seq += c;
    end

    if (!draining) cycle(1'b0, 4'd0, 64'd0, 1'b1, 1'b1);
    wait_drain();
    for (int k = 0; k < 4; k++) idle(1'b1);
    check("end_exp_empty", 64'(exp_q.size()), 64'(0));
    check("end_flush_count", 64'(flush_pulses), 64'(flushes_issued));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
